wash_timer: RTL and testbench
=============================

Name: wash_timer

Overview:
- Programmable countdown timer that serves the washing machine controller's 20-minute wash/rinse/dry interval.
- Consumes the controller's T20START request and returns T20DONE.
- Exposes the remaining time as minutes/seconds for the front-panel display.
- Sits directly beside the controller on the same divided clock and replaces the external timer stub.

Parameters:
- TICK_DIV, 50000000, CLOCK cycles per elapsed second (≥1; 1 = one second per cycle).
- DURATION_SEC, 1200, interval length in seconds (1..7679; 0 or out of range is an elaboration error).

Ports:
- CLOCK  input  1  system clock; all state updates on the falling edge.
- RESET  input  1  synchronous, active-high reset.
- T20START  input  1  level request from the controller; a low→high transition starts the interval; low aborts or clears.
- PAUSE  input  1  freezes the countdown while high (door open / unbalance).
- T20DONE  output  1  high once the interval has expired; held high while T20START stays high.
- BUSY  output  1  high while counting (including while paused).
- MIN_LEFT  output  7  remaining whole minutes.
- SEC_LEFT  output  6  remaining seconds, 0..59.

Behaviour:
- One clock; reset is synchronous and active-high. On RESET at a falling edge:
  - state=IDLE, T20DONE=0, BUSY=0, MIN_LEFT=0, SEC_LEFT=0, prescaler=0, start_prev=1.
  - start_prev=1 means a T20START level held across reset does not start a run; a fresh low→high is required.
- Start edge = T20START & ~start_prev. start_prev is registered every edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On a start edge at edge k: go to RUN, BUSY=1, prescaler=0.
  - MIN_LEFT=DURATION_SEC/60 and SEC_LEFT=DURATION_SEC%60 (elaboration constants).
  - PAUSE is ignored in IDLE.
- RUN:
  - T20START=0 has priority: abort to IDLE, BUSY=0, MIN/SEC=0, T20DONE stays 0.
  - Else if PAUSE=1: hold prescaler, MIN and SEC unchanged.
  - Else prescaler increments. At TICK_DIV-1 it wraps to 0 and one second elapses:
    - SEC≠0: SEC decrements.
    - SEC=0: SEC=59 and MIN decrements.
    - If the pre-decrement value is MIN=0, SEC=1: go to DONE at that same edge with T20DONE=1, BUSY=0, MIN=0, SEC=0.
- Latency with no pause: T20DONE rises at edge k + DURATION_SEC×TICK_DIV. Each paused cycle adds exactly one cycle.
- DONE:
  - T20DONE held at 1 while T20START=1.
  - T20START=0 at an edge: go to IDLE, T20DONE=0 after that edge.
  - A new run needs a later low→high on T20START.
- Further start edges while in RUN are impossible, since T20START would have to fall first, which aborts.
- A PAUSE and a second tick on the same cycle: PAUSE wins and the tick is deferred.
- RESET mid-run or in DONE: immediate return to reset values; no T20DONE pulse is produced.
- All outputs are registered; none are combinational from inputs.

Test Plan:
- TICK_DIV=4, DURATION_SEC=5, reset then T20START rises at edge k and is held → BUSY=1 with 0:05 after k; SEC reads 4,3,2,1 after edges k+4, k+8, k+12, k+16; T20DONE=1, BUSY=0, 0:00 after edge k+20; T20DONE stays 1 until T20START falls, then 0 one edge later.
- Same configuration, PAUSE high for 7 cycles mid-run → T20DONE rises at k+27; MIN/SEC frozen during the pause.
- TICK_DIV=1, DURATION_SEC=65 → loads 1:05; after 5 edges reads 1:00; next edge 0:59; T20DONE after edge k+65.
- T20START drops at 0:03 during RUN → IDLE, BUSY=0, 0:00, T20DONE never asserts; re-raising T20START restarts at the full 0:05.
- T20START held high while RESET is pulsed → stays IDLE, no count; T20START low then high → run starts.
- RESET asserted mid-run and in DONE → all outputs 0 on the following edge; timer remains idle after RESET is released.

Source files
------------

// File: rtl/wash_timer.sv
// Countdown timer for the washer controller's wash/rinse/dry interval.
// The controller's T20START level starts a run; the timer answers with T20DONE and shows the remaining MIN:SEC.
module wash_timer #(
    parameter int TICK_DIV     = 50000000,
    parameter int DURATION_SEC = 1200
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       T20START,
    input  logic       PAUSE,
    output logic       T20DONE,
    output logic       BUSY,
    output logic [6:0] MIN_LEFT,
    output logic [5:0] SEC_LEFT
);

    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [6:0]       LOAD_MIN = 7'(DURATION_SEC / 60);
    localparam logic [5:0]       LOAD_SEC = 6'(DURATION_SEC % 60);

    if (DURATION_SEC < 1 || DURATION_SEC > 7679) begin : g_bad_duration
        $error("wash_timer: DURATION_SEC must be in 1..7679");
    end
    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("wash_timer: TICK_DIV must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic [6:0]       min_d;
    logic [5:0]       sec_d;
    logic             done_d;
    logic             busy_d;
    logic             start_prev;
    logic             start_edge;

    assign start_edge = T20START & ~start_prev;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        min_d   = MIN_LEFT;
        sec_d   = SEC_LEFT;
        done_d  = T20DONE;
        busy_d  = BUSY;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pre_d   = '0;
                    min_d   = LOAD_MIN;
                    sec_d   = LOAD_SEC;
                end
            end
            RUN: begin
                // Dropping the request outranks both PAUSE and a pending tick.
                if (!T20START) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    pre_d   = '0;
                    min_d   = '0;
                    sec_d   = '0;
                end else if (!PAUSE) begin
                    if (pre_q == PRE_LAST) begin
                        pre_d = '0;
                        if (MIN_LEFT == 7'd0 && SEC_LEFT == 6'd1) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            sec_d   = '0;
                        end else if (SEC_LEFT != 6'd0) begin
                            sec_d = SEC_LEFT - 6'd1;
                        end else begin
                            sec_d = 6'd59;
                            min_d = MIN_LEFT - 7'd1;
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
            end
            DONE: begin
                if (!T20START) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
                min_d   = '0;
                sec_d   = '0;
            end
        endcase
    end

    // start_prev resets high so a request held through reset cannot start a run.
    always_ff @(negedge CLOCK) begin
        if (RESET) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            MIN_LEFT   <= '0;
            SEC_LEFT   <= '0;
            T20DONE    <= 1'b0;
            BUSY       <= 1'b0;
            start_prev <= 1'b1;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            MIN_LEFT   <= min_d;
            SEC_LEFT   <= sec_d;
            T20DONE    <= done_d;
            BUSY       <= busy_d;
            start_prev <= T20START;
        end
    end

endmodule

// File: tb/tb_wash_timer.sv
// Bench for wash_timer: two configurations (4 cycles/s for 5 s, 1 cycle/s for 65 s) checked
// every edge against a seconds-remaining model, plus hand-computed checkpoints.
module tb_wash_timer;

    localparam int TD_A = 4;
    localparam int DS_A = 5;
    localparam int TD_B = 1;
    localparam int DS_B = 65;

    logic       clk;
    logic       reset_a, start_a, pause_a;
    logic       done_a, busy_a;
    logic [6:0] min_a;
    logic [5:0] sec_a;
    logic       reset_b, start_b, pause_b;
    logic       done_b, busy_b;
    logic [6:0] min_b;
    logic [5:0] sec_b;

    int n_cmp;
    int n_fail;

    bit m_run[2];
    bit m_done[2];
    bit m_prev[2];
    int m_rem[2];
    int m_phase[2];

    wash_timer #(.TICK_DIV(TD_A), .DURATION_SEC(DS_A)) u_a (
        .CLOCK(clk), .RESET(reset_a), .T20START(start_a), .PAUSE(pause_a),
        .T20DONE(done_a), .BUSY(busy_a), .MIN_LEFT(min_a), .SEC_LEFT(sec_a)
    );

    wash_timer #(.TICK_DIV(TD_B), .DURATION_SEC(DS_B)) u_b (
        .CLOCK(clk), .RESET(reset_b), .T20START(start_b), .PAUSE(pause_b),
        .T20DONE(done_b), .BUSY(busy_b), .MIN_LEFT(min_b), .SEC_LEFT(sec_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // The model tracks whole seconds remaining and the cycle position inside the current second.
    task automatic model_step(input int i, input bit rst, input bit st, input bit pz,
                              input int td, input int ds);
        if (rst) begin
            m_run[i] = 1'b0; m_done[i] = 1'b0; m_rem[i] = 0; m_phase[i] = 0; m_prev[i] = 1'b1;
        end else begin
            if (m_run[i]) begin
                if (!st) begin
                    m_run[i] = 1'b0;
                    m_rem[i] = 0;
                end else if (!pz) begin
                    m_phase[i]++;
                    if (m_phase[i] == td) begin
                        m_phase[i] = 0;
                        m_rem[i]--;
                        if (m_rem[i] == 0) begin
                            m_run[i]  = 1'b0;
                            m_done[i] = 1'b1;
                        end
                    end
                end
            end else if (m_done[i]) begin
                if (!st) m_done[i] = 1'b0;
            end else if (st && !m_prev[i]) begin
                m_run[i]   = 1'b1;
                m_rem[i]   = ds;
                m_phase[i] = 0;
            end
            m_prev[i] = st;
        end
    endtask

    task automatic compare_all();
        check_output("a.done", int'(done_a), int'(m_done[0]));
        check_output("a.busy", int'(busy_a), int'(m_run[0]));
        check_output("a.min",  int'(min_a),  m_rem[0] / 60);
        check_output("a.sec",  int'(sec_a),  m_rem[0] % 60);
        check_output("b.done", int'(done_b), int'(m_done[1]));
        check_output("b.busy", int'(busy_b), int'(m_run[1]));
        check_output("b.min",  int'(min_b),  m_rem[1] / 60);
        check_output("b.sec",  int'(sec_b),  m_rem[1] % 60);
    endtask

    // One active (falling) edge: advance the model with the inputs the DUT sees, then compare.
    task automatic tick();
        @(negedge clk);
        model_step(0, reset_a, start_a, pause_a, TD_A, DS_A);
        model_step(1, reset_b, start_b, pause_b, TD_B, DS_B);
        #2;
        compare_all();
    endtask

    task automatic apply_stimulus(input int n);
        repeat (n) tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset_a = 1'b1; start_a = 1'b0; pause_a = 1'b0;
        reset_b = 1'b1; start_b = 1'b0; pause_b = 1'b0;

        apply_stimulus(2);
        check_output("reset a.busy", int'(busy_a), 0);
        check_output("reset a.done", int'(done_a), 0);
        check_output("reset b.min", int'(min_b), 0);
        reset_a = 1'b0; reset_b = 1'b0;
        apply_stimulus(1);

        $display("[TB] plain run, 4 cycles per second, 5 seconds");
        start_a = 1'b1;
        apply_stimulus(1);
        check_output("load a.busy", int'(busy_a), 1);
        check_output("load a.min", int'(min_a), 0);
        check_output("load a.sec", int'(sec_a), 5);
        apply_stimulus(4);
        check_output("k+4 a.sec", int'(sec_a), 4);
        apply_stimulus(15);
        check_output("k+19 a.done", int'(done_a), 0);
        check_output("k+19 a.sec", int'(sec_a), 1);
        apply_stimulus(1);
        check_output("k+20 a.done", int'(done_a), 1);
        check_output("k+20 a.busy", int'(busy_a), 0);
        check_output("k+20 a.sec", int'(sec_a), 0);
        apply_stimulus(3);
        check_output("hold a.done", int'(done_a), 1);
        start_a = 1'b0;
        apply_stimulus(1);
        check_output("release a.done", int'(done_a), 0);

        $display("[TB] seven paused cycles mid-run");
        start_a = 1'b1;
        apply_stimulus(1);
        apply_stimulus(6);
        check_output("pre-pause a.sec", int'(sec_a), 4);
        pause_a = 1'b1;
        apply_stimulus(7);
        check_output("paused a.sec", int'(sec_a), 4);
        check_output("paused a.busy", int'(busy_a), 1);
        pause_a = 1'b0;
        apply_stimulus(13);
        check_output("k+26 a.done", int'(done_a), 0);
        apply_stimulus(1);
        check_output("k+27 a.done", int'(done_a), 1);
        start_a = 1'b0;
        apply_stimulus(1);

        $display("[TB] abort at 0:03 then restart");
        start_a = 1'b1;
        apply_stimulus(1);
        apply_stimulus(8);
        check_output("pre-abort a.sec", int'(sec_a), 3);
        start_a = 1'b0;
        apply_stimulus(1);
        check_output("abort a.busy", int'(busy_a), 0);
        check_output("abort a.sec", int'(sec_a), 0);
        check_output("abort a.done", int'(done_a), 0);
        apply_stimulus(25);
        start_a = 1'b1;
        apply_stimulus(1);
        check_output("restart a.sec", int'(sec_a), 5);
        check_output("restart a.busy", int'(busy_a), 1);
        start_a = 1'b0;
        apply_stimulus(1);

        $display("[TB] request held across reset");
        start_a = 1'b1; reset_a = 1'b1;
        apply_stimulus(2);
        reset_a = 1'b0;
        apply_stimulus(3);
        check_output("held a.busy", int'(busy_a), 0);
        check_output("held a.sec", int'(sec_a), 0);
        start_a = 1'b0;
        apply_stimulus(1);
        start_a = 1'b1;
        apply_stimulus(1);
        check_output("fresh a.busy", int'(busy_a), 1);
        check_output("fresh a.sec", int'(sec_a), 5);

        $display("[TB] reset mid-run and in done");
        apply_stimulus(5);
        reset_a = 1'b1;
        apply_stimulus(1);
        check_output("midrun rst a.busy", int'(busy_a), 0);
        check_output("midrun rst a.sec", int'(sec_a), 0);
        reset_a = 1'b0;
        apply_stimulus(3);
        check_output("after rst a.busy", int'(busy_a), 0);
        start_a = 1'b0;
        apply_stimulus(1);
        start_a = 1'b1;
        apply_stimulus(1);
        apply_stimulus(20);
        check_output("pre-rst a.done", int'(done_a), 1);
        reset_a = 1'b1;
        apply_stimulus(1);
        check_output("done rst a.done", int'(done_a), 0);
        reset_a = 1'b0;
        apply_stimulus(2);
        check_output("idle a.busy", int'(busy_a), 0);
        check_output("idle a.done", int'(done_a), 0);
        start_a = 1'b0;
        apply_stimulus(1);

        $display("[TB] one cycle per second, 65 seconds");
        start_b = 1'b1;
        apply_stimulus(1);
        check_output("load b.min", int'(min_b), 1);
        check_output("load b.sec", int'(sec_b), 5);
        apply_stimulus(5);
        check_output("k+5 b.min", int'(min_b), 1);
        check_output("k+5 b.sec", int'(sec_b), 0);
        apply_stimulus(1);
        check_output("k+6 b.min", int'(min_b), 0);
        check_output("k+6 b.sec", int'(sec_b), 59);
        apply_stimulus(58);
        check_output("k+64 b.done", int'(done_b), 0);
        check_output("k+64 b.sec", int'(sec_b), 1);
        apply_stimulus(1);
        check_output("k+65 b.done", int'(done_b), 1);
        check_output("k+65 b.sec", int'(sec_b), 0);
        start_b = 1'b0;
        apply_stimulus(1);
        check_output("release b.done", int'(done_b), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
